// File: rtl/mult_test_pkg.sv
// Shared types and constants for the 2x2 multiplier response checker.
package mult_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] MISR_POLY    = 8'h1D;
  localparam logic [7:0] DEFAULT_SEED = 8'hFF;

  // One MISR step: shift left, fold the polynomial on carry-out, absorb the response nibble.
  function automatic logic [7:0] misr_step(input logic [7:0] cur, input logic [3:0] din);
    misr_step = {cur[6:0], 1'b0} ^ (cur[7] ? MISR_POLY : 8'h00) ^ {4'b0000, din};
  endfunction

endpackage

// File: rtl/misr8.sv
// 8-bit multiple-input signature register compacting 4-bit responses.
module misr8
  import mult_test_pkg::*;
#(
  parameter logic [7:0] RST_VAL = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       en,
  input  logic [3:0] din,
  output logic [7:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= RST_VAL;
    end else if (load) begin
      sig <= seed;
    end else if (en) begin
      sig <= misr_step(sig, din);
    end
  end

endmodule

// File: rtl/mult2x2_resp_checker.sv
// Session-based checker comparing a 2x2 multiplier's responses against the exact product.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | results held; waiting for start
//   ST_RUN  | accepting vectors, comparing and compacting responses
//   ST_DONE | one-cycle done pulse, then back to idle
module mult2x2_resp_checker
  import mult_test_pkg::*;
#(
  parameter int         CNT_W = 8,
  parameter logic [7:0] SEED  = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [1:0]       vec_a,
  input  logic [1:0]       vec_b,
  input  logic [3:0]       dut_q,
  output logic             done,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [3:0]       first_fail_q,
  output logic [7:0]       signature,
  output logic             trojan_flag
);

  state_t           state, state_next;
  logic [CNT_W-1:0] num_lat;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] fail_next;
  logic [3:0]       golden;
  logic             accept;
  logic             mismatch;
  logic             last;
  logic             misr_load;

  assign golden    = {2'b00, vec_a} * {2'b00, vec_b};
  assign accept    = vec_valid && (state == ST_RUN);
  assign mismatch  = (dut_q != golden);
  assign last      = (idx == num_lat - CNT_W'(1));
  assign fail_next = (accept && mismatch && (fail_cnt != '1)) ? fail_cnt + CNT_W'(1) : fail_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    vec_ready  = 1'b0;
    done       = 1'b0;
    misr_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          misr_load  = 1'b1;
          state_next = (num_vec == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        vec_ready = 1'b1;
        if (accept && last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_lat        <= '0;
      idx            <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '1;
      first_fail_q   <= 4'h0;
      trojan_flag    <= 1'b0;
    end else if ((state == ST_IDLE) && start) begin
      num_lat        <= num_vec;
      idx            <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '1;
      first_fail_q   <= 4'h0;
      trojan_flag    <= 1'b0;
    end else if (accept) begin
      idx      <= idx + CNT_W'(1);
      fail_cnt <= fail_next;
      // fail_cnt saturates and never wraps, so zero means no earlier mismatch
      if (mismatch && (fail_cnt == '0)) begin
        first_fail_idx <= idx;
        first_fail_q   <= dut_q;
      end
      if (last) begin
        trojan_flag <= (fail_next != '0);
      end
    end
  end

  misr8 #(
    .RST_VAL (SEED)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (misr_load),
    .seed  (SEED),
    .en    (accept),
    .din   (dut_q),
    .sig   (signature)
  );

endmodule

// File: tb/tb_mult2x2_resp_checker.sv
// Randomized self-checking bench for mult2x2_resp_checker against a session-level model.
module tb_mult2x2_resp_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] num_vec;
  logic       vec_valid;
  logic       vec_ready;
  logic [1:0] vec_a;
  logic [1:0] vec_b;
  logic [3:0] dut_q;
  logic       done;
  logic [7:0] fail_cnt;
  logic [7:0] first_fail_idx;
  logic [3:0] first_fail_q;
  logic [7:0] signature;
  logic       trojan_flag;

  int checks = 0;
  int errors = 0;
  int va [256];
  int vb [256];
  int vq [256];
  int last_fail;
  int last_sig;

  always #5 clk = ~clk;

  mult2x2_resp_checker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .num_vec        (num_vec),
    .vec_valid      (vec_valid),
    .vec_ready      (vec_ready),
    .vec_a          (vec_a),
    .vec_b          (vec_b),
    .dut_q          (dut_q),
    .done           (done),
    .fail_cnt       (fail_cnt),
    .first_fail_idx (first_fail_idx),
    .first_fail_q   (first_fail_q),
    .signature      (signature),
    .trojan_flag    (trojan_flag)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Signature arithmetic done on plain integers: double mod 256, fold 29 on overflow, xor response.
  function automatic int misr_model(input int m, input int q);
    int r;
    r = (m * 2) % 256;
    if (m >= 128) r = r ^ 29;
    return r ^ q;
  endfunction

  task automatic fill_sweep();
    for (int k = 0; k < 16; k++) begin
      va[k] = k / 4;
      vb[k] = k % 4;
      vq[k] = va[k] * vb[k];
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_fail_cnt"}, fail_cnt, 0);
    check({tag, "_first_idx"}, first_fail_idx, 255);
    check({tag, "_first_q"}, first_fail_q, 0);
    check({tag, "_signature"}, signature, 255);
    check({tag, "_trojan"}, trojan_flag, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ready"}, vec_ready, 0);
  endtask

  task automatic run_session(input string tag, input int n, input bit bp, input bit stray);
    int  exp_fail = 0;
    int  exp_idx = 255;
    int  exp_q = 0;
    int  exp_sig = 255;
    int  i = 0;
    int  cyc = 0;
    bit  seen = 0;
    bit  v;
    for (int k = 0; k < n; k++) begin
      if (vq[k] != va[k] * vb[k]) begin
        if (exp_fail == 0) begin
          exp_idx = k;
          exp_q   = vq[k];
        end
        if (exp_fail < 255) exp_fail++;
      end
      exp_sig = misr_model(exp_sig, vq[k]);
    end
    @(negedge clk);
    start   = 1'b1;
    num_vec = 8'(n);
    @(negedge clk);
    start   = 1'b0;
    while (cyc < 4000) begin
      if (done) begin
        seen = 1;
        check({tag, "_accepted"}, i, n);
        check({tag, "_ready_in_done"}, vec_ready, 0);
        break;
      end
      v = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stray && (i == n / 2)) begin
        start   = 1'b1;
        num_vec = 8'd2;
      end else begin
        start = 1'b0;
      end
      vec_valid = v;
      vec_a     = (i < n) ? 2'(va[i]) : 2'd0;
      vec_b     = (i < n) ? 2'(vb[i]) : 2'd0;
      dut_q     = (i < n) ? 4'(vq[i]) : 4'd0;
      if (v && vec_ready) i++;
      @(negedge clk);
      cyc++;
    end
    start     = 1'b0;
    vec_valid = 1'b0;
    check({tag, "_done_seen"}, int'(seen), 1);
    check({tag, "_fail_cnt"}, fail_cnt, exp_fail);
    check({tag, "_first_idx"}, first_fail_idx, exp_idx);
    check({tag, "_first_q"}, first_fail_q, exp_q);
    check({tag, "_signature"}, signature, exp_sig);
    check({tag, "_trojan"}, trojan_flag, int'(exp_fail != 0));
    @(negedge clk);
    check({tag, "_done_single"}, done, 0);
    last_fail = exp_fail;
    last_sig  = exp_sig;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    num_vec   = 8'd0;
    vec_valid = 1'b0;
    vec_a     = 2'd0;
    vec_b     = 2'd0;
    dut_q     = 4'd0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    fill_sweep();
    run_session("clean", 16, 0, 0);

    vq[11] = 4;
    run_session("fault1", 16, 0, 0);

    fill_sweep();
    vq[3]  = 1;
    vq[15] = 8;
    run_session("fault2", 16, 0, 0);

    run_session("zero", 0, 0, 0);

    fill_sweep();
    vq[7] = 2;
    run_session("bp_stray", 16, 1, 1);

    // vectors presented while idle must not disturb held results
    for (int k = 0; k < 5; k++) begin
      vec_valid = 1'b1;
      vec_a     = 2'd3;
      vec_b     = 2'd3;
      dut_q     = 4'hF;
      @(negedge clk);
    end
    vec_valid = 1'b0;
    check("idle_fail_cnt", fail_cnt, last_fail);
    check("idle_signature", signature, last_sig);
    check("idle_ready", vec_ready, 0);

    fill_sweep();
    vq[2] = 7;
    @(negedge clk);
    start   = 1'b1;
    num_vec = 8'd16;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vec_valid = 1'b1;
      vec_a     = 2'(va[k]);
      vec_b     = 2'(vb[k]);
      dut_q     = 4'(vq[k]);
      @(negedge clk);
    end
    vec_valid = 1'b0;
    check("mid_fail_cnt", fail_cnt, 1);
    check("mid_first_idx", first_fail_idx, 2);
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_reset_done", done, 0);
      check("post_reset_ready", vec_ready, 0);
    end
    fill_sweep();
    run_session("after_reset", 16, 0, 0);

    for (int s = 0; s < 4; s++) begin
      int n;
      n = int'($urandom_range(1, 40));
      for (int k = 0; k < n; k++) begin
        va[k] = int'($urandom_range(0, 3));
        vb[k] = int'($urandom_range(0, 3));
        vq[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : va[k] * vb[k];
      end
      run_session($sformatf("rand%0d", s), n, 1'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
